// File: rtl/time_set_pkg.sv
// time_set_pkg: shared types, limits and calendar helpers for the time-set editor.
//   state_t     editor FSM states; E_* codes 1..7 equal the edit_field codes
//   field_t     edit_field codes used by the display blink logic
//   tfields_t   packed bundle of the edited date/time fields
//   is_leap, days_in_month  Gregorian calendar helpers
package time_set_pkg;

  typedef enum logic [3:0] {
    RUN    = 4'd0,
    E_YEAR = 4'd1,
    E_MON  = 4'd2,
    E_DAY  = 4'd3,
    E_HOUR = 4'd4,
    E_MIN  = 4'd5,
    E_SEC  = 4'd6,
    E_WEEK = 4'd7,
    COMMIT = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    F_NONE, F_YEAR, F_MON, F_DAY, F_HOUR, F_MIN, F_SEC, F_WEEK
  } field_t;

  localparam int NUM_BTN = 4;
  localparam int B_MODE  = 0;
  localparam int B_NEXT  = 1;
  localparam int B_UP    = 2;
  localparam int B_DOWN  = 3;

  localparam logic [14:0] YEAR_MIN   = 15'd1;
  localparam logic [14:0] YEAR_MAX   = 15'd9999;
  localparam logic [14:0] RESET_YEAR = 15'd2023;

  typedef struct packed {
    logic [14:0] year;
    logic [3:0]  month;
    logic [4:0]  day;
    logic [5:0]  hour;
    logic [5:0]  minute;
    logic [5:0]  second;
    logic [3:0]  week;
  } tfields_t;

  function automatic logic is_leap(input logic [14:0] y);
    return (y[1:0] == 2'b00) &&
           (((y % 15'd100) != 15'd0) || ((y % 15'd400) == 15'd0));
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [14:0] y);
    case (m)
      4'd2:                     days_in_month = is_leap(y) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  days_in_month = 5'd30;
      default:                  days_in_month = 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stability counter and rising-edge press pulse.
//   clk, rst_n  system clock, async active-low reset
//   raw         raw button input (asynchronous)
//   level       debounced button level
//   press       1-cycle pulse, coincident with level going high
module btn_debounce #(
  parameter int DB_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DB_CYC + 1);

  logic           s1, s2;
  logic [CW-1:0]  cnt;

  // The synchronised input must differ from the accepted level for DB_CYC
  // consecutive cycles before it is taken; any bounce back restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYC - 1)) begin
        level <= s2;
        press <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_editor.sv
// time_set_editor: button-driven date/time editor feeding the running-time counter.
//   In RUN, mode=1 so the counter free-runs; in edit states and COMMIT, mode=0 so the
//   counter loads year_d..week_s. Edit entry preloads fields from cur_* (sanitised).
//   Inputs : clk, rst_n, btn_mode/next/up/down (raw), cur_year..cur_week (live counter)
//   Outputs: year_d, month_d, day_d, hour_d, min_d, sec_d, week_s, mode, edit_field
//   Option : TIME_SET_AUTO_REPEAT_EN -- holding up/down for 500 ms repeats steps at REPEAT_HZ.
module time_set_editor
  import time_set_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int REPEAT_HZ   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [15:0] cur_year,
  input  logic [5:0]  cur_month,
  input  logic [10:0] cur_day,
  input  logic [10:0] cur_hour,
  input  logic [10:0] cur_minute,
  input  logic [10:0] cur_second,
  input  logic [10:0] cur_week,
  output logic [14:0] year_d,
  output logic [3:0]  month_d,
  output logic [4:0]  day_d,
  output logic [5:0]  hour_d,
  output logic [5:0]  min_d,
  output logic [5:0]  sec_d,
  output logic [3:0]  week_s,
  output logic [3:0]  mode,
  output logic [2:0]  edit_field
);
  localparam int DB_RAW = DEBOUNCE_MS * (CLK_HZ / 1000);
  localparam int DB_CYC = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int CCW    = $clog2(CLK_HZ + 1);

  logic [NUM_BTN-1:0] raw, level, press;
  logic               step_up, step_dn;
  state_t             state, state_nx;
  tfields_t           f, f_nx, cap;
  logic [CCW-1:0]     ccnt;
  logic [14:0]        yr;
  logic [3:0]         mo;
  logic [4:0]         dm;
  logic               unused_hi;

  assign raw = {btn_down, btn_up, btn_next, btn_mode};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DB_CYC(DB_CYC)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .level (level[i]),
      .press (press[i])
    );
  end

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int HOLD_CYC = (CLK_HZ / 2 < 1) ? 1 : CLK_HZ / 2;
  localparam int RPT_RAW  = (CLK_HZ / REPEAT_HZ < 1) ? 1 : CLK_HZ / REPEAT_HZ;
  localparam int RPT_CYC  = (RPT_RAW > HOLD_CYC) ? HOLD_CYC : RPT_RAW;
  localparam int RCW      = $clog2(HOLD_CYC + 1);

  logic [RCW-1:0] rcnt;
  logic           rpt_arm, rpt_fire;

  // Armed only while exactly one of up/down is held in an edit state. After the
  // first fire the counter rewinds by one repeat period, so later fires come
  // every RPT_CYC cycles.
  assign rpt_arm  = (state != RUN) && (state != COMMIT) && (level[B_UP] ^ level[B_DOWN]);
  assign rpt_fire = rpt_arm && (rcnt == RCW'(HOLD_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rcnt <= '0;
    else if (!rpt_arm) rcnt <= '0;
    else if (rpt_fire) rcnt <= RCW'(HOLD_CYC - RPT_CYC);
    else               rcnt <= rcnt + RCW'(1);
  end

  assign step_up = press[B_UP]   | (rpt_fire & level[B_UP]);
  assign step_dn = press[B_DOWN] | (rpt_fire & level[B_DOWN]);
`else
  logic unused_rpt;
  assign unused_rpt = (REPEAT_HZ > 0);
  assign step_up    = press[B_UP];
  assign step_dn    = press[B_DOWN];
`endif

  // Only the low bits of the counter fields carry the value.
  assign unused_hi = ^{cur_year[15], cur_month[5:4], cur_day[10:5], cur_hour[10:6],
                       cur_minute[10:6], cur_second[10:6], cur_week[10:4], level};

  // Preload with out-of-range fields forced to their minimum.
  always_comb begin
    cap.year   = cur_year[14:0];
    cap.month  = cur_month[3:0];
    cap.day    = cur_day[4:0];
    cap.hour   = cur_hour[5:0];
    cap.minute = cur_minute[5:0];
    cap.second = cur_second[5:0];
    cap.week   = cur_week[3:0];
    if (cap.year < YEAR_MIN || cap.year > YEAR_MAX) cap.year = YEAR_MIN;
    if (cap.month == 4'd0 || cap.month > 4'd12)     cap.month = 4'd1;
    if (cap.day == 5'd0 || cap.day > days_in_month(cap.month, cap.year)) cap.day = 5'd1;
    if (cap.hour > 6'd23)                           cap.hour = 6'd0;
    if (cap.minute > 6'd59)                         cap.minute = 6'd0;
    if (cap.second > 6'd59)                         cap.second = 6'd0;
    if (cap.week == 4'd0 || cap.week > 4'd7)        cap.week = 4'd1;
  end

  always_comb begin
    state_nx = state;
    f_nx     = f;
    yr       = f.year;
    mo       = f.month;
    dm       = days_in_month(f.month, f.year);
    case (state)
      RUN:    if (press[B_MODE]) begin
                state_nx = E_YEAR;
                f_nx     = cap;
              end
      COMMIT: if (ccnt == CCW'(CLK_HZ - 1)) state_nx = RUN;
      default: begin
        if (press[B_MODE]) begin
          state_nx = COMMIT;
        end else if (press[B_NEXT]) begin
          state_nx = (state == E_WEEK) ? E_YEAR : state_t'(state + 4'd1);
        end else if (step_up ^ step_dn) begin
          case (state)
            E_YEAR: begin
              if (step_up) yr = (f.year == YEAR_MAX) ? YEAR_MIN : f.year + 15'd1;
              else         yr = (f.year == YEAR_MIN) ? YEAR_MAX : f.year - 15'd1;
              f_nx.year = yr;
              dm        = days_in_month(f.month, yr);
              if (f.day > dm) f_nx.day = dm;
            end
            E_MON: begin
              if (step_up) mo = (f.month == 4'd12) ? 4'd1 : f.month + 4'd1;
              else         mo = (f.month == 4'd1) ? 4'd12 : f.month - 4'd1;
              f_nx.month = mo;
              dm         = days_in_month(mo, f.year);
              if (f.day > dm) f_nx.day = dm;
            end
            E_DAY:
              if (step_up) f_nx.day = (f.day >= dm) ? 5'd1 : f.day + 5'd1;
              else         f_nx.day = (f.day <= 5'd1) ? dm : f.day - 5'd1;
            E_HOUR:
              if (step_up) f_nx.hour = (f.hour == 6'd23) ? 6'd0 : f.hour + 6'd1;
              else         f_nx.hour = (f.hour == 6'd0) ? 6'd23 : f.hour - 6'd1;
            E_MIN:
              if (step_up) f_nx.minute = (f.minute == 6'd59) ? 6'd0 : f.minute + 6'd1;
              else         f_nx.minute = (f.minute == 6'd0) ? 6'd59 : f.minute - 6'd1;
            E_SEC:
              if (step_up) f_nx.second = (f.second == 6'd59) ? 6'd0 : f.second + 6'd1;
              else         f_nx.second = (f.second == 6'd0) ? 6'd59 : f.second - 6'd1;
            E_WEEK:
              if (step_up) f_nx.week = (f.week == 4'd7) ? 4'd1 : f.week + 4'd1;
              else         f_nx.week = (f.week == 4'd1) ? 4'd7 : f.week - 4'd1;
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      f     <= '{year: RESET_YEAR, month: 4'd1, day: 5'd1, hour: 6'd0,
                 minute: 6'd0, second: 6'd0, week: 4'd1};
      ccnt  <= '0;
    end else begin
      state <= state_nx;
      f     <= f_nx;
      ccnt  <= (state == COMMIT) ? ccnt + CCW'(1) : '0;
    end
  end

  assign year_d     = f.year;
  assign month_d    = f.month;
  assign day_d      = f.day;
  assign hour_d     = f.hour;
  assign min_d      = f.minute;
  assign sec_d      = f.second;
  assign week_s     = f.week;
  assign mode       = (state == RUN) ? 4'd1 : 4'd0;
  // E_* codes equal their field codes; RUN=0 and COMMIT=8 both read 0 here.
  assign edit_field = state[2:0];

endmodule

// File: tb/tb_time_set_editor.sv
module tb_time_set_editor;
  localparam int CLK_HZ      = 1000;
  localparam int DEBOUNCE_MS = 3;
  localparam int REPEAT_HZ   = 8;
  localparam logic [3:0] BM = 4'd1, BN = 4'd2, BU = 4'd4, BD = 4'd8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [15:0] cur_year = '0;
  logic [5:0]  cur_month = '0;
  logic [10:0] cur_day = '0, cur_hour = '0, cur_minute = '0, cur_second = '0, cur_week = '0;
  logic [14:0] year_d;
  logic [3:0]  month_d, week_s, mode;
  logic [4:0]  day_d;
  logic [5:0]  hour_d, min_d, sec_d;
  logic [2:0]  edit_field;

  always #5 clk = ~clk;

  time_set_editor #(.CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS), .REPEAT_HZ(REPEAT_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up),
    .btn_down(btn_down), .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second), .cur_week(cur_week),
    .year_d(year_d), .month_d(month_d), .day_d(day_d), .hour_d(hour_d), .min_d(min_d),
    .sec_d(sec_d), .week_s(week_s), .mode(mode), .edit_field(edit_field));

  int nchk = 0, nerr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int y, m, d, h, mi, s, w, md, ef);
    chk({tag, ".year"}, int'(year_d), y);
    chk({tag, ".month"}, int'(month_d), m);
    chk({tag, ".day"}, int'(day_d), d);
    chk({tag, ".hour"}, int'(hour_d), h);
    chk({tag, ".min"}, int'(min_d), mi);
    chk({tag, ".sec"}, int'(sec_d), s);
    chk({tag, ".week"}, int'(week_s), w);
    chk({tag, ".mode"}, int'(mode), md);
    chk({tag, ".edit_field"}, int'(edit_field), ef);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask);
    {btn_down, btn_up, btn_next, btn_mode} = mask;
    cyc(10);
    {btn_down, btn_up, btn_next, btn_mode} = 4'd0;
    cyc(12);
  endtask

  task automatic set_cur(input int y, m, d, h, mi, s, w);
    cur_year = 16'(y); cur_month = 6'(m); cur_day = 11'(d); cur_hour = 11'(h);
    cur_minute = 11'(mi); cur_second = 11'(s); cur_week = 11'(w);
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (mode != 4'd1 && n < 3 * CLK_HZ) begin
      cyc(1);
      n++;
    end
    chk({tag, ".back_to_run"}, int'(mode), 1);
  endtask

  // ---------------- reference model (calendar arithmetic) ----------------
  int my, mm, mdd, mh, mmi, ms, mw, mst;  // mst: 0 run, 1..7 field, 8 commit

  function automatic int mdays(input int m, input int y);
    bit leap = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    if (m == 2) return leap ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic model_reset();
    my = 2023; mm = 1; mdd = 1; mh = 0; mmi = 0; ms = 0; mw = 1; mst = 0;
  endtask

  task automatic model_press(input logic [3:0] mask);
    bit up = mask[2];
    if (mst == 8) return;
    if (mst == 0) begin
      if (mask[0]) begin
        my = int'(cur_year) % 32768;   if (my < 1 || my > 9999) my = 1;
        mm = int'(cur_month) % 16;     if (mm < 1 || mm > 12) mm = 1;
        mdd = int'(cur_day) % 32;      if (mdd < 1 || mdd > mdays(mm, my)) mdd = 1;
        mh = int'(cur_hour) % 64;      if (mh > 23) mh = 0;
        mmi = int'(cur_minute) % 64;   if (mmi > 59) mmi = 0;
        ms = int'(cur_second) % 64;    if (ms > 59) ms = 0;
        mw = int'(cur_week) % 16;      if (mw < 1 || mw > 7) mw = 1;
        mst = 1;
      end
    end else if (mask[0]) mst = 8;
    else if (mask[1]) mst = mst % 7 + 1;
    else if (mask[2] != mask[3]) begin
      case (mst)
        1: begin my = up ? my % 9999 + 1 : (my == 1 ? 9999 : my - 1);
                 if (mdd > mdays(mm, my)) mdd = mdays(mm, my); end
        2: begin mm = up ? mm % 12 + 1 : (mm == 1 ? 12 : mm - 1);
                 if (mdd > mdays(mm, my)) mdd = mdays(mm, my); end
        3: mdd = up ? mdd % mdays(mm, my) + 1 : (mdd == 1 ? mdays(mm, my) : mdd - 1);
        4: mh = up ? (mh + 1) % 24 : (mh + 23) % 24;
        5: mmi = up ? (mmi + 1) % 60 : (mmi + 59) % 60;
        6: ms = up ? (ms + 1) % 60 : (ms + 59) % 60;
        default: mw = up ? mw % 7 + 1 : (mw + 5) % 7 + 1;
      endcase
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] btn;
    int y, m, d, h, mi, s, w, md, ef;
    bit waitc;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [3:0] b, input int y, m, d, h, mi, s, w, md, ef, input bit wc);
    vec_t v;
    v.btn = b; v.y = y; v.m = m; v.d = d; v.h = h; v.mi = mi; v.s = s; v.w = w;
    v.md = md; v.ef = ef; v.waitc = wc;
    tbl.push_back(v);
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [3:0] mask;
    int r;

    // block A: 2024-03-31 10:20:30 wk7
    add(BM, 2024,3,31,10,20,30,7, 0,1,0);
    add(BN, 2024,3,31,10,20,30,7, 0,2,0);
    add(BD, 2024,2,29,10,20,30,7, 0,2,0);
    for (int i = 3; i <= 7; i++) add(BN, 2024,2,29,10,20,30,7, 0,i,0);
    add(BN, 2024,2,29,10,20,30,7, 0,1,0);
    add(BU, 2025,2,28,10,20,30,7, 0,1,0);
    add(BU|BD, 2025,2,28,10,20,30,7, 0,1,0);
    add(BD, 2024,2,28,10,20,30,7, 0,1,0);
    add(BM, 2024,2,28,10,20,30,7, 0,0,1);
    // block B: 1900-02-28 23:59:59 wk6 (index 13)
    add(BM, 1900,2,28,23,59,59,6, 0,1,0);
    add(BN, 1900,2,28,23,59,59,6, 0,2,0);
    add(BN, 1900,2,28,23,59,59,6, 0,3,0);
    add(BU, 1900,2,1,23,59,59,6, 0,3,0);
    add(BN, 1900,2,1,23,59,59,6, 0,4,0);
    add(BN, 1900,2,1,23,59,59,6, 0,5,0);
    add(BU, 1900,2,1,23,0,59,6, 0,5,0);
    add(BN, 1900,2,1,23,0,59,6, 0,6,0);
    add(BD, 1900,2,1,23,0,58,6, 0,6,0);
    add(BU, 1900,2,1,23,0,59,6, 0,6,0);
    add(BU, 1900,2,1,23,0,0,6, 0,6,0);
    add(BN, 1900,2,1,23,0,0,6, 0,7,0);
    add(BU, 1900,2,1,23,0,0,7, 0,7,0);
    add(BU, 1900,2,1,23,0,0,1, 0,7,0);
    add(BN, 1900,2,1,23,0,0,1, 0,1,0);
    add(BM, 1900,2,1,23,0,0,1, 0,0,1);
    // block C: out-of-range preload with junk high bits (index 29)
    add(BM, 1,12,31,5,0,0,1, 0,1,0);
    add(BD, 9999,12,31,5,0,0,1, 0,1,0);
    add(BU, 1,12,31,5,0,0,1, 0,1,0);
    add(BN, 1,12,31,5,0,0,1, 0,2,0);
    add(BU, 1,1,31,5,0,0,1, 0,2,0);
    add(BD, 1,12,31,5,0,0,1, 0,2,0);
    add(BD, 1,11,30,5,0,0,1, 0,2,0);
    add(BM, 1,11,30,5,0,0,1, 0,0,1);

    // reset
    cyc(3);
    chk_all("in_reset", 2023,1,1,0,0,0,1, 1,0);
    rst_n = 1'b1;
    cyc(3);
    chk_all("after_reset", 2023,1,1,0,0,0,1, 1,0);
    press(BU);
    chk_all("up_in_run", 2023,1,1,0,0,0,1, 1,0);

    foreach (tbl[i]) begin
      if (i == 0)  set_cur(2024,3,31,10,20,30,7);
      if (i == 13) set_cur(1900,2,28,23,59,59,6);
      if (i == 29) set_cur(0, 60, 31+64, 69, 0, 60, 0);
      press(tbl[i].btn);
      chk_all($sformatf("vec%0d", i), tbl[i].y, tbl[i].m, tbl[i].d, tbl[i].h, tbl[i].mi,
              tbl[i].s, tbl[i].w, tbl[i].md, tbl[i].ef);
      if (tbl[i].waitc) wait_run($sformatf("vec%0d", i));
    end

    // COMMIT length and ignored presses
    set_cur(2030,6,15,12,30,45,3);
    press(BM);
    repeat (5) press(BN);
    chk("commit.pre_field", int'(edit_field), 6);
    btn_mode = 1'b1;
    cnt = 0;
    while (edit_field != 3'd0 && cnt < 50) begin cyc(1); cnt++; end
    chk("commit.enter", int'(edit_field), 0);
    btn_mode = 1'b0;
    cnt = 1;
    while (cnt < 3 * CLK_HZ) begin
      cyc(1);
      if (mode == 4'd1) break;
      cnt++;
      if (cnt == 50)  {btn_up, btn_next} = 2'b11;
      if (cnt == 80)  {btn_up, btn_next} = 2'b00;
      if (cnt == 120) btn_mode = 1'b1;
      if (cnt == 150) btn_mode = 1'b0;
    end
    chk("commit.length", cnt, CLK_HZ);
    cyc(5);
    chk_all("commit.after", 2030,6,15,12,30,45,3, 1,0);

    // hold up just under 1.5 s in E_SEC from 0
    set_cur(2030,6,15,12,30,0,3);
    press(BM);
    repeat (5) press(BN);
    btn_up = 1'b1;
    cyc(CLK_HZ * 3 / 2 - 10);
    btn_up = 1'b0;
    cyc(20);
`ifdef TIME_SET_AUTO_REPEAT_EN
    chk_all("hold_up", 2030,6,15,12,30,9,3, 0,6);
`else
    chk_all("hold_up", 2030,6,15,12,30,1,3, 0,6);
`endif
    press(BM);
    wait_run("hold_up");

    // reset in the middle of COMMIT
    press(BM);
    press(BU);
    press(BU);
    chk("midrst.year_edit", int'(year_d), 2032);
    press(BM);
    cyc(100);
    rst_n = 1'b0;
    #1;
    chk_all("midrst.async", 2023,1,1,0,0,0,1, 1,0);
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    chk_all("midrst.after", 2023,1,1,0,0,0,1, 1,0);

    // randomized operations against the model
    model_reset();
    for (int k = 0; k < 90; k++) begin
      if (mst == 0) begin
        if ($urandom_range(0, 4) != 0) begin
          cur_year   = 16'($urandom_range(0, 1) * 32768 + $urandom_range(0, 10100));
          cur_month  = 6'($urandom_range(0, 3) * 16 + $urandom_range(0, 14));
          cur_day    = 11'($urandom_range(0, 63) * 32 + $urandom_range(0, 31));
          cur_hour   = 11'($urandom_range(0, 31) * 64 + $urandom_range(0, 25));
          cur_minute = 11'($urandom_range(0, 31) * 64 + $urandom_range(0, 61));
          cur_second = 11'($urandom_range(0, 31) * 64 + $urandom_range(0, 61));
          cur_week   = 11'($urandom_range(0, 127) * 16 + $urandom_range(0, 8));
          mask = BM;
        end else mask = 4'($urandom_range(1, 7) * 2);
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 6)       mask = BM;
        else if (r < 30) mask = BN;
        else if (r < 62) mask = BU;
        else if (r < 94) mask = BD;
        else if (r < 97) mask = BU | BD;
        else             mask = 4'($urandom_range(1, 15));
      end
      press(mask);
      model_press(mask);
      chk_all($sformatf("rnd%0d", k), my, mm, mdd, mh, mmi, ms, mw,
              (mst == 0) ? 1 : 0, (mst >= 1 && mst <= 7) ? mst : 0);
      if (mst == 8) begin
        wait_run($sformatf("rnd%0d", k));
        mst = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
